ifetch_queue: RTL

Instruction fetch queue on the consumer side of the PC generator. It takes the current PC and returns the PC-advance enable `pc_wen`. For each address it issues a single-outstanding read to instruction memory and buffers the returned 16-bit instructions, each tagged with its fetch address, in a small FIFO for decode. A `flush` from decode/branch discards both the buffered entries and the in-flight fetch.

---
 rtl/ifetch_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues one outstanding instruction-memory read
// per PC and buffers the returned words, tagged with their fetch address,
// in a small FIFO for decode. A flush discards buffered and in-flight data.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] pc,
  output logic        pc_wen,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    IDLE = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   req_addr;
  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Fetch sequencing: capture PC when there is room, strobe the request,
  // then wait for the data; a flush while in flight turns the fetch stale.
  always_comb begin
    state_nxt = state;
    pc_wen    = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    push      = 1'b0;
    case (state)
      BOOT: state_nxt = IDLE;
      IDLE: begin
        if (count < FULL && !flush) begin
          pc_wen    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_addr  = req_addr;
        state_nxt = flush ? DROP : WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          push      = !flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign inst_valid      = (count != '0);
  assign pop             = inst_valid & inst_ready & ~flush;
  assign {inst_pc, inst} = fifo_mem[rd_ptr];

  // State register and the address latched for the current fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= BOOT;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      if (pc_wen) req_addr <= pc;
    end
  end

  // FIFO storage; the IDLE room check guarantees a free slot on push.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_addr, mem_rdata};
  end

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
